// File: rtl/sign_mag_add_arb.sv
// sign_mag_add_arb: two-requester round-robin arbiter sharing one N-bit sign-magnitude adder.
// Define SMA_SAT_EN to saturate the magnitude on equal-sign overflow instead of wrapping.
module sign_mag_add_arb #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req0_i,
    input  logic [N-1:0] a0_i,
    input  logic [N-1:0] b0_i,
    input  logic         req1_i,
    input  logic [N-1:0] a1_i,
    input  logic [N-1:0] b1_i,
    output logic         done0_o,
    output logic         done1_o,
    output logic [N-1:0] sum_o,
    output logic         ovf_o,
    output logic         busy_o
);
    localparam int M = N - 1;

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

    state_e       state_q, state_d;
    logic         id_q, id_d, last_q, last_d, ovf_q, ovf_d;
    logic         done0_q, done0_d, done1_q, done1_d;
    logic [N-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic         sa, sb, same, ge, sgn, res_ovf, grant;
    logic [M-1:0] ma, mb, mag;
    logic [M:0]   s;

    always_comb begin
        sa      = a_q[N-1];
        sb      = b_q[N-1];
        ma      = a_q[M-1:0];
        mb      = b_q[M-1:0];
        s       = {1'b0, ma} + {1'b0, mb};
        same    = sa == sb;
        ge      = ma >= mb;
        res_ovf = same & s[M];
`ifdef SMA_SAT_EN
        mag     = same ? (s[M] ? '1 : s[M-1:0]) : (ge ? ma - mb : mb - ma);
`else
        mag     = same ? s[M-1:0] : (ge ? ma - mb : mb - ma);
`endif
        // a zero magnitude always carries a positive sign
        sgn     = (same ? sa : (ge ? sa : sb)) & |mag;
    end

    assign grant = (req0_i & req1_i) ? ~last_q : req1_i;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        case (state_q)
            IDLE: if (req0_i | req1_i) begin
                id_d    = grant;
                a_d     = grant ? a1_i : a0_i;
                b_d     = grant ? b1_i : b0_i;
                state_d = CALC;
            end
            CALC: begin
                sum_d   = {sgn, mag};
                ovf_d   = res_ovf;
                state_d = RESP;
            end
            RESP: begin
                done0_d = ~id_q;
                done1_d = id_q;
                last_d  = id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
        end
    end

    assign done0_o = done0_q;
    assign done1_o = done1_q;
    assign sum_o   = sum_q;
    assign ovf_o   = ovf_q;
    assign busy_o  = state_q != IDLE;
endmodule

// File: tb/tb_sign_mag_add_arb.sv
// tb_sign_mag_add_arb: directed and random checks of sign_mag_add_arb against an integer-arithmetic model.
// Honours SMA_SAT_EN the same way as the design.
module tb_sign_mag_add_arb;
    localparam int N    = 4;
    localparam int M    = N - 1;
    localparam int MAXM = (1 << M) - 1;

    logic         clk = 1'b0, rst_n = 1'b0, req0 = 1'b0, req1 = 1'b0;
    logic [N-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         done0, done1, ovf, busy;
    logic [N-1:0] sum;
    int           total = 0, passed = 0, fails = 0;

    always #5 clk = ~clk;

    sign_mag_add_arb #(.N(N)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_i(req0), .a0_i(a0), .b0_i(b0),
        .req1_i(req1), .a1_i(a1), .b1_i(b1),
        .done0_o(done0), .done1_o(done1),
        .sum_o(sum), .ovf_o(ovf), .busy_o(busy)
    );

    // returns {ovf, sum} from signed integer arithmetic on the decoded operands
    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        int va, vb, t, mg;
        logic ov, neg;
        logic [M-1:0] mo;
        va = a[N-1] ? -int'(a[M-1:0]) : int'(a[M-1:0]);
        vb = b[N-1] ? -int'(b[M-1:0]) : int'(b[M-1:0]);
        t  = va + vb;
        mg = t < 0 ? -t : t;
        ov = mg > MAXM;
`ifdef SMA_SAT_EN
        if (ov) mg = MAXM;
`else
        mg = mg % (MAXM + 1);
`endif
        mo  = mg[M-1:0];
        neg = (t < 0) && (mg != 0);
        return {ov, neg, mo};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input int r, input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
        logic [N:0] e;
        int cyc;
        bit seen;
        e = model(a, b);
        @(negedge clk);
        if (r == 0) begin req0 = 1'b1; a0 = a; b0 = b; end
        else        begin req1 = 1'b1; a1 = a; b1 = b; end
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            cyc++;
            seen = done0 | done1;
        end
        check({tag, " latency"}, cyc, 3);
        check({tag, " done"}, {done1, done0}, r == 0 ? 2'b01 : 2'b10);
        check({tag, " sum"}, sum, e[N-1:0]);
        check({tag, " ovf"}, ovf, e[N]);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check({tag, " pulse end"}, {done1, done0, busy}, 3'b000);
    endtask

    initial begin
        logic [N-1:0] ca0, cb0, ca1, cb1;
        logic [7:0]   v;
        logic [N:0]   e;
        int           n, cyc;
        bit           seen;

        // reset values
        repeat (2) @(negedge clk);
        check("reset outputs", {done1, done0, busy, ovf, sum}, 0);
        rst_n = 1'b1;

        // directed arithmetic cases
        run_op(0, 4'b0011, 4'b0010, "p3+p2");
        check("p3+p2 const", sum, 4'b0101);
        run_op(1, 4'b0101, 4'b1011, "p5+m3");
        check("p5+m3 const", sum, 4'b0010);
        run_op(1, 4'b1011, 4'b0011, "m3+p3");
        check("m3+p3 const", sum, 4'b0000);
        run_op(1, 4'b1000, 4'b1000, "m0+m0");
        check("m0+m0 const", sum, 4'b0000);
        run_op(0, 4'b0110, 4'b0101, "p6+p5");
`ifdef SMA_SAT_EN
        check("p6+p5 const", {ovf, sum}, 5'b10111);
`else
        check("p6+p5 const", {ovf, sum}, 5'b10011);
`endif
        run_op(0, 4'b1110, 4'b1101, "m6+m5");
`ifdef SMA_SAT_EN
        check("m6+m5 const", {ovf, sum}, 5'b11111);
`else
        check("m6+m5 const", {ovf, sum}, 5'b11011);
`endif

        // contention from reset: service must alternate starting with requester 0
        @(negedge clk);
        rst_n = 1'b0;
        ca0 = N'($urandom); cb0 = N'($urandom); ca1 = N'($urandom); cb1 = N'($urandom);
        a0 = ca0; b0 = cb0; a1 = ca1; b1 = cb1;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done0 | done1) begin
                e = (n % 2 == 0) ? model(ca0, cb0) : model(ca1, cb1);
                check("arb order", {done1, done0}, (n % 2 == 0) ? 2'b01 : 2'b10);
                check("arb sum", {ovf, sum}, e);
                n++;
            end
        end
        check("arb count", n, 4);
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);

        // reset during CALC aborts the operation silently
        a0 = 4'b0001; b0 = 4'b0001; req0 = 1'b1;
        @(negedge clk);
        check("abort busy", busy, 1'b1);
        rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        check("abort async", {done1, done0, busy, ovf, sum}, 0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | done0 | done1;
        end
        check("abort no done", seen, 1'b0);
        check("abort outputs", {done1, done0, busy, ovf, sum}, 0);
        rst_n = 1'b1;
        run_op(0, 4'b0010, 4'b1001, "post abort");

        // random single operations on random requesters
        for (int i = 0; i < 20; i++)
            run_op(int'($urandom_range(1, 0)), N'($urandom), N'($urandom), "random");

        // exhaustive sweep through requester 0
        for (int i = 0; i < 256; i++) begin
            v = i[7:0];
            run_op(0, v[7:4], v[3:0], "sweep");
            check("sweep negzero", sum == 4'b1000, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
